// File: rtl/pipe_delay_line.sv
// pipe_delay_line: DEPTH-stage payload delay line with a valid bit per stage,
// global stall and flush, and asynchronous active-high reset.
// Optional feature macro: PIPE_OCCUPANCY_EN adds an occupancy counter port
// tracking the number of valid stages.
// Invalid stages always hold zero data, so out_data is zero whenever
// out_valid is low.
module pipe_delay_line #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         stall,
  input  logic                         flush,
`ifdef PIPE_OCCUPANCY_EN
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
`endif
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Next-state: flush beats stall, stall beats shift; bubbles enter with zero data
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_d[k] = '0;
      end
    end else if (!stall) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_valid ? in_data : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  // Stage registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Outputs come straight from the last stage, no input-to-output path
  always_comb begin
    out_valid = valid_q[DEPTH-1];
    out_data  = data_q[DEPTH-1];
  end

`ifdef PIPE_OCCUPANCY_EN
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [OccW-1:0] occ_q, occ_d;

  // Count tracks popcount(valid_q): one enters at stage 0, one leaves at the end
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (!stall) begin
      occ_d = occ_q + OccW'(in_valid) - OccW'(valid_q[DEPTH-1]);
    end
  end

  // Occupancy register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule
